mcol_state_serial: RTL
======================

// Module: mcol_state_serial
// PURPOSE
//  Sequential, share-wise MixColumns engine for the Fides threshold implementations.
//  Takes a full masked state (SHARES shares) through a valid/ready handshake.
//  Applies the Fides binary MixColumns to LANES column-groups per cycle, buffering in place.
//  Returns the result through a second handshake. Replaces the fully combinational state mixer
//  where area matters; sits between the S-box layer and the key/round-constant addition.
// PARAMETERS
//  WORD_W  5  bits per state word (5 = Fides-160, 6 = Fides-192)
//  NCOL    8  number of 4-word groups in the state; STATE_W = 4*WORD_W*NCOL
//  SHARES  3  number of Boolean shares; each share is processed independently
//  LANES   1  groups transformed per cycle; must divide NCOL (otherwise $error at elaboration)
// PORTS
//  clk        in   1                  clock, rising edge
//  rst        in   1                  asynchronous reset, active-high
//  in_valid   in   1                  in_data valid
//  in_ready   out  1                  engine can accept a state
//  in_data    in   SHARES*STATE_W     share 0 in MSBs; within a share, group 0 in MSBs
//  out_valid  out  1                  out_data holds a finished state
//  out_ready  in   1                  consumer accepts out_data
//  out_data   out  SHARES*STATE_W     same packing as in_data
//  busy       out  1                  high in BUSY state
// BEHAVIOUR
//  Group function, per share and per group (a1..a4, a1 in MSBs):
//    y1 = a2^a3^a4, y2 = a1^a3^a4, y3 = a1^a2^a4, y4 = a1^a2^a3.
//  Pure XOR on each share. No term ever mixes two shares; this preserves non-completeness.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//   - IDLE: in_ready=1. When in_valid=1, buf<=in_data, cnt<=0, go to BUSY.
//   - BUSY: each cycle, groups cnt*LANES .. cnt*LANES+LANES-1 of every share are replaced in buf.
//     cnt increments. After the cycle with cnt = NCOL/LANES-1, go to DONE.
//   - DONE: out_valid=1 and out_data=buf (registered, stable). When out_ready=1, go to IDLE.
//  Latency: first out_valid occurs NCOL/LANES cycles after the accept edge (8 at the defaults).
//  Throughput: at most one state per NCOL/LANES+2 cycles.
//  in_ready is 0 in BUSY and DONE. in_valid is ignored there; there is no overlap.
//  DONE with out_ready=1: return to IDLE. in_ready rises the next cycle (no same-cycle re-accept).
//  cnt is $clog2(NCOL/LANES) bits wide, min 1. cnt never wraps; it is cleared on accept.
//  Reset (async, any state): state=IDLE, cnt=0, buf=0.
//   Outputs after reset: in_ready=1, out_valid=0, out_data=0, busy=0.
//  Reset during BUSY or DONE discards the state and produces no partial output.
//  LANES=NCOL is legal: one BUSY cycle, then DONE.
// CONFIGURATION
//  MCOL_BYPASS_EN defined:
//   - Adds input port `bypass` (1 bit), sampled with the accept.
//   - If sampled 1, BUSY leaves buf unchanged (for rounds that skip MixColumns).
//   - Cycle timing is identical, so bypass is not visible through timing.
//  MCOL_BYPASS_EN undefined: port absent; every accepted state is mixed.
// TESTING
//  1. Reset in IDLE, then release. Require in_ready=1, out_valid=0, out_data=0, busy=0.
//  2. WORD_W=5, share 0 group 0 = {1,2,4,8}, all else 0.
//     Require out_valid 8 cycles after accept, group 0 = {14,13,11,7}, and all other bits 0.
//  3. Random 3-share state. Require the XOR of the output shares to equal MixColumns of the
//     XOR of the input shares. Require each output share to equal MixColumns of its own input share.
//  4. Hold out_ready=0 for 5 cycles in DONE. Require out_data stable, in_ready=0,
//     and a second in_valid to be ignored. Then out_ready=1 -> in_ready=1 the next cycle.
//  5. Assert rst at BUSY cycle 4. Require immediate out_valid=0 and buf=0.
//     A new state accepted afterwards produces the correct result.
//  6. LANES=8 with MCOL_BYPASS_EN and bypass=1. Require out_valid 1 cycle after accept
//     and out_data==in_data.

Source files
------------

// File: rtl/mcol_state_serial.sv
// Share-wise serial Fides MixColumns engine: accepts a masked state, mixes LANES groups per cycle in place.
// Optional MCOL_BYPASS_EN adds a `bypass` input that keeps the state unmixed with identical timing.
module mcol_state_serial #(
  parameter int unsigned WORD_W = 5,
  parameter int unsigned NCOL   = 8,
  parameter int unsigned SHARES = 3,
  parameter int unsigned LANES  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [SHARES*4*WORD_W*NCOL-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [SHARES*4*WORD_W*NCOL-1:0] out_data,
`ifdef MCOL_BYPASS_EN
  input  logic                            bypass,
`endif
  output logic                            busy
);

  localparam int unsigned GRP_W   = 4 * WORD_W;
  localparam int unsigned STATE_W = GRP_W * NCOL;
  localparam int unsigned DATA_W  = SHARES * STATE_W;
  localparam int unsigned NSTEP   = (LANES == 0) ? 1 : NCOL / LANES;
  localparam int unsigned CNT_W   = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEP - 1);

  if (LANES == 0 || (NCOL % LANES) != 0) begin : g_lanes_check
    $error("mcol_state_serial: LANES (%0d) must divide NCOL (%0d)", LANES, NCOL);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  buf_q, buf_d, buf_mix;
`ifdef MCOL_BYPASS_EN
  logic               byp_q, byp_d;
`endif

  // Mix the groups selected by cnt in every share; shares never interact.
  always_comb begin
    int unsigned g;
    int unsigned base;
    logic [WORD_W-1:0] a1, a2, a3, a4;
    buf_mix = buf_q;
    g    = 0;
    base = 0;
    a1   = '0;
    a2   = '0;
    a3   = '0;
    a4   = '0;
    for (int unsigned s = 0; s < SHARES; s++) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        g    = 32'(cnt_q) * LANES + l;
        base = (SHARES - 1 - s) * STATE_W + (NCOL - 1 - g) * GRP_W;
        {a1, a2, a3, a4} = buf_q[base +: GRP_W];
        buf_mix[base +: GRP_W] = {a2 ^ a3 ^ a4, a1 ^ a3 ^ a4, a1 ^ a2 ^ a4, a1 ^ a2 ^ a3};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
`ifdef MCOL_BYPASS_EN
    byp_d   = byp_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_d   = in_data;
          cnt_d   = '0;
          state_d = BUSY;
`ifdef MCOL_BYPASS_EN
          byp_d   = bypass;
`endif
        end
      end
      BUSY: begin
`ifdef MCOL_BYPASS_EN
        if (!byp_q) buf_d = buf_mix;
`else
        buf_d = buf_mix;
`endif
        // cnt holds on the last step so it never wraps
        if (cnt_q == CNT_LAST) state_d = DONE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
`ifdef MCOL_BYPASS_EN
      byp_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
`ifdef MCOL_BYPASS_EN
      byp_q   <= byp_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign out_data  = buf_q;

endmodule
